// File: rtl/spi_cmd_ctrl_if.sv
// Bus bundle between the SPI byte front-end, the accelerator and spi_cmd_ctrl.
// The slave modport is the controller's view; the master modport is the environment's view.
interface spi_cmd_ctrl_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       cs_n;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       acc_start;
  logic [7:0] acc_arg;
  logic       acc_done;
  logic [2:0] led;
  logic       busy;
  logic       err;

  modport slave (
    input  rx_valid, rx_data, cs_n, acc_done,
    output tx_data, tx_load, acc_start, acc_arg, led, busy, err
  );

  modport master (
    output rx_valid, rx_data, cs_n, acc_done,
    input  tx_data, tx_load, acc_start, acc_arg, led, busy, err
  );
endinterface

// File: rtl/spi_cmd_ctrl.sv
// SPI command decoder: LED write, accelerator job with timeout, and status read.
// All outputs are registered; the next-state logic computes every register's next value.
module spi_cmd_ctrl #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic          clk,
  input logic          reset,
  spi_cmd_ctrl_if.slave bus
);

  // Wide enough to hold TIMEOUT_CYCLES itself so the saturation limit never wraps.
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, GET_ARG, EXEC, WAIT_ACC, RESP} state_t;

  state_t        state_reg, state_next;
  logic [1:0]    opcode_reg, opcode_next;
  logic [7:0]    arg_reg, arg_next;
  logic [2:0]    led_reg, led_next;
  logic [7:0]    tx_data_reg, tx_data_next;
  logic          tx_load_reg, tx_load_next;
  logic          acc_start_reg, acc_start_next;
  logic [7:0]    acc_arg_reg, acc_arg_next;
  logic          busy_reg, busy_next;
  logic          err_reg, err_next;
  logic          done_reg, done_next;
  logic [CW-1:0] count_reg, count_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      opcode_reg    <= 2'd0;
      arg_reg       <= 8'h00;
      led_reg       <= 3'b111;
      tx_data_reg   <= 8'h00;
      tx_load_reg   <= 1'b0;
      acc_start_reg <= 1'b0;
      acc_arg_reg   <= 8'h00;
      busy_reg      <= 1'b0;
      err_reg       <= 1'b0;
      done_reg      <= 1'b0;
      count_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      opcode_reg    <= opcode_next;
      arg_reg       <= arg_next;
      led_reg       <= led_next;
      tx_data_reg   <= tx_data_next;
      tx_load_reg   <= tx_load_next;
      acc_start_reg <= acc_start_next;
      acc_arg_reg   <= acc_arg_next;
      busy_reg      <= busy_next;
      err_reg       <= err_next;
      done_reg      <= done_next;
      count_reg     <= count_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    opcode_next    = opcode_reg;
    arg_next       = arg_reg;
    led_next       = led_reg;
    tx_data_next   = tx_data_reg;
    tx_load_next   = 1'b0;
    acc_start_next = 1'b0;
    acc_arg_next   = acc_arg_reg;
    busy_next      = busy_reg;
    err_next       = err_reg;
    done_next      = done_reg;
    count_next     = count_reg;

    case (state_reg)
      IDLE: begin
        if (bus.rx_valid) begin
          case (bus.rx_data)
            8'h01, 8'h02: begin
              opcode_next = bus.rx_data[1:0];
              state_next  = GET_ARG;
            end
            8'h03: state_next = RESP;
            default: begin
              err_next     = 1'b1;
              tx_data_next = 8'hEE;
              tx_load_next = 1'b1;
            end
          endcase
        end
      end

      GET_ARG: begin
        // A frame that ends before its argument arrives is discarded silently.
        if (bus.cs_n) begin
          state_next = IDLE;
        end else if (bus.rx_valid) begin
          arg_next   = bus.rx_data;
          state_next = EXEC;
        end
      end

      EXEC: begin
        if (opcode_reg == 2'd1) begin
          led_next     = arg_reg[2:0];
          tx_data_next = 8'hA1;
          tx_load_next = 1'b1;
          state_next   = IDLE;
        end else begin
          acc_arg_next   = arg_reg;
          acc_start_next = 1'b1;
          busy_next      = 1'b1;
          count_next     = '0;
          state_next     = WAIT_ACC;
        end
      end

      WAIT_ACC: begin
        if (count_reg != CNT_LAST) count_next = count_reg + 1'b1;
        // Completion takes priority over an expiring timeout in the same cycle.
        if (bus.acc_done) begin
          busy_next    = 1'b0;
          done_next    = 1'b1;
          tx_data_next = 8'hA2;
          tx_load_next = 1'b1;
          state_next   = IDLE;
        end else if (count_reg == CNT_LAST) begin
          busy_next    = 1'b0;
          err_next     = 1'b1;
          tx_data_next = 8'hE1;
          tx_load_next = 1'b1;
          state_next   = IDLE;
        end else if (bus.rx_valid) begin
          tx_data_next = 8'hB5;
          tx_load_next = 1'b1;
        end
      end

      RESP: begin
        tx_data_next = {busy_reg, err_reg, done_reg, 2'b00, led_reg};
        tx_load_next = 1'b1;
        err_next     = 1'b0;
        done_next    = 1'b0;
        state_next   = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.tx_data   = tx_data_reg;
  assign bus.tx_load   = tx_load_reg;
  assign bus.acc_start = acc_start_reg;
  assign bus.acc_arg   = acc_arg_reg;
  assign bus.led       = led_reg;
  assign bus.busy      = busy_reg;
  assign bus.err       = err_reg;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed bench for spi_cmd_ctrl with a short timeout; inputs change and
// outputs are sampled on the falling clock edge.
module tb_spi_cmd_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   tx_cnt = 0;
  int   start_cnt = 0;
  int   tx_base, start_base;
  logic [7:0] last_tx = 8'h00;

  spi_cmd_ctrl_if ifc ();

  spi_cmd_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  // Pulse counters so one-cycle strobes are observed regardless of check timing.
  always @(negedge clk) begin
    if (ifc.tx_load) begin
      tx_cnt  <= tx_cnt + 1;
      last_tx <= ifc.tx_data;
    end
    if (ifc.acc_start) start_cnt <= start_cnt + 1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
      $display("[TB] %s: got %0h expected %0h ok", tag, obs, exp);
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    ifc.rx_valid = 1'b1;
    ifc.rx_data  = b;
    @(negedge clk);
    ifc.rx_valid = 1'b0;
    ifc.rx_data  = 8'h00;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    ifc.rx_valid = 1'b0;
    ifc.rx_data  = 8'h00;
    ifc.cs_n     = 1'b0;
    ifc.acc_done = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_led", 16'(ifc.led), 16'h7);
    check("rst_tx_data", 16'(ifc.tx_data), 16'h00);
    check("rst_tx_load", 16'(ifc.tx_load), 16'h0);
    check("rst_acc_start", 16'(ifc.acc_start), 16'h0);
    check("rst_acc_arg", 16'(ifc.acc_arg), 16'h00);
    check("rst_busy", 16'(ifc.busy), 16'h0);
    check("rst_err", 16'(ifc.err), 16'h0);
    reset = 1'b1;

    // LED command aborted by cs_n, then status read
    tx_base = tx_cnt;
    send_byte(8'h01);
    ifc.cs_n = 1'b1;
    @(negedge clk);
    ifc.cs_n = 1'b0;
    settle();
    check("abort_no_tx", 16'(tx_cnt - tx_base), 16'd0);
    check("abort_led", 16'(ifc.led), 16'h7);
    send_byte(8'h03);
    settle();
    check("abort_status", 16'(last_tx), 16'h07);
    check("abort_status_cnt", 16'(tx_cnt - tx_base), 16'd1);

    // LED write
    tx_base = tx_cnt;
    send_byte(8'h01);
    send_byte(8'h05);
    settle();
    check("led_write", 16'(ifc.led), 16'h5);
    check("led_tx", 16'(last_tx), 16'hA1);
    check("led_tx_cnt", 16'(tx_cnt - tx_base), 16'd1);

    // Accelerator job with a byte arriving mid-job and completion after ~10 cycles
    tx_base = tx_cnt;
    start_base = start_cnt;
    send_byte(8'h02);
    send_byte(8'h3C);
    @(negedge clk);
    check("acc_busy_on", 16'(ifc.busy), 16'h1);
    check("acc_arg", 16'(ifc.acc_arg), 16'h3C);
    @(negedge clk);
    ifc.rx_valid = 1'b1;
    ifc.rx_data  = 8'h01;
    @(negedge clk);
    ifc.rx_valid = 1'b0;
    ifc.rx_data  = 8'h00;
    check("wait_rx_tx", 16'(ifc.tx_data), 16'hB5);
    check("wait_rx_busy", 16'(ifc.busy), 16'h1);
    repeat (6) @(negedge clk);
    ifc.acc_done = 1'b1;
    @(negedge clk);
    ifc.acc_done = 1'b0;
    check("acc_done_tx", 16'(ifc.tx_data), 16'hA2);
    check("acc_done_busy", 16'(ifc.busy), 16'h0);
    settle();
    check("acc_start_cnt", 16'(start_cnt - start_base), 16'd1);
    check("acc_tx_cnt", 16'(tx_cnt - tx_base), 16'd2);
    send_byte(8'h03);
    settle();
    check("status_done", 16'(last_tx), 16'h25);
    send_byte(8'h03);
    settle();
    check("status_cleared", 16'(last_tx), 16'h05);

    // Illegal opcode
    send_byte(8'h7F);
    settle();
    check("bad_op_tx", 16'(last_tx), 16'hEE);
    check("bad_op_err", 16'(ifc.err), 16'h1);
    send_byte(8'h03);
    settle();
    check("status_err", 16'(last_tx), 16'h45);
    check("err_cleared", 16'(ifc.err), 16'h0);

    // Reset during a job, then a stray completion
    send_byte(8'h02);
    send_byte(8'h11);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_busy", 16'(ifc.busy), 16'h0);
    check("midrst_acc_arg", 16'(ifc.acc_arg), 16'h00);
    check("midrst_led", 16'(ifc.led), 16'h7);
    check("midrst_tx_data", 16'(ifc.tx_data), 16'h00);
    @(negedge clk);
    reset = 1'b1;
    tx_base = tx_cnt;
    @(negedge clk);
    ifc.acc_done = 1'b1;
    @(negedge clk);
    ifc.acc_done = 1'b0;
    settle();
    check("stray_done_no_tx", 16'(tx_cnt - tx_base), 16'd0);
    check("stray_done_busy", 16'(ifc.busy), 16'h0);

    // Timeout with TIMEOUT_CYCLES=16
    send_byte(8'h02);
    send_byte(8'h00);
    @(negedge clk);
    check("to_busy_start", 16'(ifc.busy), 16'h1);
    repeat (15) @(negedge clk);
    check("to_busy_last", 16'(ifc.busy), 16'h1);
    @(negedge clk);
    check("to_busy_off", 16'(ifc.busy), 16'h0);
    check("to_tx", 16'(ifc.tx_data), 16'hE1);
    check("to_tx_load", 16'(ifc.tx_load), 16'h1);
    check("to_err", 16'(ifc.err), 16'h1);
    send_byte(8'h03);
    settle();
    check("to_status", 16'(last_tx), 16'h47);
    check("to_err_cleared", 16'(ifc.err), 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
